// File: rtl/vector_output_buffer.sv
// Capture FIFO for CPU output vectors with a valid/ready drain port.
// Each entry leaves as one full-vector beat or as one beat per lane.
module vector_output_buffer #(
    parameter int DATA_WIDTH  = 16,
    parameter int VECTOR_SIZE = 6,
    parameter int DEPTH       = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              outFlag,
    input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] out,
    input  logic                              serialMode,
    input  logic                              outReady,
    output logic                              outValid,
    output logic [DATA_WIDTH*VECTOR_SIZE-1:0] outData,
    output logic [$clog2(VECTOR_SIZE)-1:0]    outLane,
    output logic                              outLast,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              full,
    output logic                              overflow,
    input  logic                              clearOverflow
);
    localparam int VW = DATA_WIDTH * VECTOR_SIZE;
    localparam int LW = $clog2(VECTOR_SIZE);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(VECTOR_SIZE - 1);

    typedef enum logic [1:0] {IDLE, VECTOR, SERIAL} state_t;

    state_t                state;
    state_t                stateNext;
    logic [VW-1:0]         mem [DEPTH];
    logic [PW-1:0]         rdPtr;
    logic [PW-1:0]         wrPtr;
    logic [LW-1:0]         lane;
    logic [CW-1:0]         countNext;
    logic [VW-1:0]         head;
    logic [DATA_WIDTH-1:0] laneData;
    logic                  push;
    logic                  handshake;
    logic                  pop;

    assign full      = (count == CW'(DEPTH));
    assign push      = outFlag && !full;
    assign handshake = outValid && outReady;
    assign pop       = handshake && outLast;

    always_comb begin
        countNext = count;
        if (push && !pop)
            countNext = count + 1'b1;
        else if (pop && !push)
            countNext = count - 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // serialMode only matters when a new entry is about to be presented
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (count != '0)
                    stateNext = serialMode ? SERIAL : VECTOR;
            end
            default: begin
                if (pop) begin
                    if (countNext == '0)
                        stateNext = IDLE;
                    else
                        stateNext = serialMode ? SERIAL : VECTOR;
                end
            end
        endcase
    end

    always_comb begin
        head     = mem[rdPtr];
        laneData = '0;
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            if (lane == LW'(i))
                laneData = head[i*DATA_WIDTH +: DATA_WIDTH];
        end
        outValid = (state != IDLE);
        outLane  = (state == SERIAL) ? lane : '0;
        outLast  = (state == VECTOR) ||
                   ((state == SERIAL) && (lane == LAST_LANE));
        case (state)
            VECTOR:  outData = head;
            SERIAL:  outData = VW'(laneData);
            default: outData = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            lane     <= '0;
            overflow <= 1'b0;
        end else begin
            count <= countNext;
            if (push)
                wrPtr <= wrPtr + 1'b1;
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            if (handshake && state == SERIAL)
                lane <= outLast ? '0 : lane + 1'b1;
            if (clearOverflow)
                overflow <= 1'b0;
            else if (outFlag && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wrPtr] <= out;
    end
endmodule

// File: tb/tb_vector_output_buffer.sv
// Directed bench for vector_output_buffer with default parameters.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_vector_output_buffer;
    logic        clock = 1'b0;
    logic        reset;
    logic        outFlag;
    logic [95:0] out;
    logic        serialMode;
    logic        outReady;
    logic        outValid;
    logic [95:0] outData;
    logic [2:0]  outLane;
    logic        outLast;
    logic [3:0]  count;
    logic        full;
    logic        overflow;
    logic        clearOverflow;

    int total = 0;
    int bad   = 0;

    localparam logic [95:0] VEC  = 96'h0006_0005_0004_0003_0002_0001;
    localparam logic [95:0] VEC7 = 96'h000c_000b_000a_0009_0008_0007;

    vector_output_buffer dut (
        .clock(clock),
        .reset(reset),
        .outFlag(outFlag),
        .out(out),
        .serialMode(serialMode),
        .outReady(outReady),
        .outValid(outValid),
        .outData(outData),
        .outLane(outLane),
        .outLast(outLast),
        .count(count),
        .full(full),
        .overflow(overflow),
        .clearOverflow(clearOverflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int expLane;
        int cyc;
        reset         = 1'b0;
        outFlag       = 1'b0;
        out           = '0;
        serialMode    = 1'b0;
        outReady      = 1'b1;
        clearOverflow = 1'b0;
        #3;
        chk("rst_valid", outValid, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", outData, 0);
        chk("rst_last", outLast, 0);
        chk("rst_lane", outLane, 0);
        tick();
        reset = 1'b1;
        tick();

        // vector mode, single beat
        outFlag = 1'b1;
        out     = VEC;
        tick();
        outFlag = 1'b0;
        chk("vec_cnt1", count, 1);
        chk("vec_novalid", outValid, 0);
        tick();
        chk("vec_valid", outValid, 1);
        chk("vec_data", outData, VEC);
        chk("vec_last", outLast, 1);
        chk("vec_lane", outLane, 0);
        tick();
        chk("vec_done", outValid, 0);
        chk("vec_cnt0", count, 0);

        // serial mode, six lanes
        serialMode = 1'b1;
        outFlag    = 1'b1;
        out        = VEC;
        tick();
        outFlag = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("ser_valid", outValid, 1);
            chk("ser_lane", outLane, i);
            chk("ser_data", outData, i + 1);
            chk("ser_last", outLast, (i == 5));
            tick();
        end
        chk("ser_done", outValid, 0);
        chk("ser_cnt0", count, 0);

        // overflow: nine captures into an eight-deep FIFO
        serialMode = 1'b0;
        outReady   = 1'b0;
        for (int v = 1; v <= 9; v++) begin
            outFlag = 1'b1;
            out     = 96'(v);
            tick();
        end
        outFlag = 1'b0;
        chk("ovf_cnt", count, 8);
        chk("ovf_full", full, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", outData, 1);
        // clear wins over a same-edge drop
        outFlag       = 1'b1;
        out           = 96'd10;
        clearOverflow = 1'b1;
        tick();
        outFlag       = 1'b0;
        clearOverflow = 1'b0;
        chk("clr_prio", overflow, 0);
        chk("clr_cnt", count, 8);
        outReady = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            chk("drain_valid", outValid, 1);
            chk("drain_data", outData, v);
            tick();
        end
        chk("drain_done", outValid, 0);
        chk("drain_cnt", count, 0);

        // serial backpressure, ready pattern 1,0,0,1
        serialMode = 1'b1;
        outFlag    = 1'b1;
        out        = VEC;
        tick();
        outFlag = 1'b0;
        tick();
        expLane = 0;
        cyc     = 0;
        while (expLane < 6 && cyc < 40) begin
            outReady = (cyc % 4 == 0) || (cyc % 4 == 3);
            chk("bp_valid", outValid, 1);
            chk("bp_lane", outLane, expLane);
            chk("bp_data", outData, expLane + 1);
            tick();
            if (outReady)
                expLane++;
            cyc++;
        end
        chk("bp_lanes", expLane, 6);
        chk("bp_done", outValid, 0);

        // reset in the middle of a serial entry
        outReady = 1'b0;
        for (int v = 1; v <= 3; v++) begin
            outFlag = 1'b1;
            out     = VEC;
            tick();
        end
        outFlag  = 1'b0;
        outReady = 1'b1;
        tick();
        tick();
        chk("mr_lane2", outLane, 2);
        chk("mr_cnt3", count, 3);
        reset = 1'b0;
        #1;
        chk("mr_cnt", count, 0);
        chk("mr_valid", outValid, 0);
        chk("mr_ovf", overflow, 0);
        @(posedge clock);
        @(negedge clock);
        reset   = 1'b1;
        outFlag = 1'b1;
        out     = VEC7;
        tick();
        outFlag = 1'b0;
        tick();
        chk("mr_new_lane", outLane, 0);
        chk("mr_new_data", outData, 7);
        chk("mr_new_cnt", count, 1);
        repeat (6) tick();
        chk("mr_new_done", outValid, 0);

        // simultaneous push and pop in vector mode
        serialMode = 1'b0;
        outReady   = 1'b0;
        outFlag    = 1'b1;
        out        = 96'hA;
        tick();
        outFlag = 1'b0;
        tick();
        chk("pp_cnt1", count, 1);
        chk("pp_dataA", outData, 96'hA);
        outReady = 1'b1;
        outFlag  = 1'b1;
        out      = 96'hB;
        tick();
        outFlag = 1'b0;
        chk("pp_cnt", count, 1);
        chk("pp_valid", outValid, 1);
        chk("pp_dataB", outData, 96'hB);
        tick();
        chk("pp_done", outValid, 0);
        chk("pp_cnt0", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vector_output_buffer.md
VECTOR_OUTPUT_BUFFER -- requirements
Module: vector_output_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, lane width in bits.
REQ-002 SHALL have parameter VECTOR_SIZE, default 6, lanes per vector (>=2).
REQ-003 SHALL have parameter DEPTH, default 8, FIFO entries (power of 2, >=2).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clock  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-007 SHALL have port outFlag  input  1  CPU output strobe; capture request.
REQ-008 SHALL have port out  input  DATA_WIDTH*VECTOR_SIZE  CPU output vector; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port serialMode  input  1  1 = emit one lane per beat, 0 = emit whole vector per beat.
REQ-010 SHALL have port outReady  input  1  sink accepts current beat.
REQ-011 SHALL have port outValid  output  1  beat valid.
REQ-012 SHALL have port outData  output  DATA_WIDTH*VECTOR_SIZE  beat payload.
REQ-013 SHALL have port outLane  output  $clog2(VECTOR_SIZE)  lane index of current serial beat; 0 in vector mode.
REQ-014 SHALL have port outLast  output  1  final beat of current entry.
REQ-015 SHALL have port count  output  $clog2(DEPTH+1)  FIFO occupancy.
REQ-016 SHALL have port full  output  1  count == DEPTH.
REQ-017 SHALL have port overflow  output  1  sticky: a capture was dropped.
REQ-018 SHALL have port clearOverflow  input  1  synchronous clear of overflow.

Function
REQ-019 SHALL push out into the FIFO tail on a rising edge where outFlag=1 and count<DEPTH at that edge; there is no full-bypass, even with a simultaneous pop.
REQ-020 SHALL drop the capture and set overflow on an edge where outFlag=1 and full=1; FIFO contents and count are unchanged.
REQ-021 SHALL give clearOverflow priority over a same-edge overflow set (overflow reads 0 after that edge).
REQ-022 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-023 SHALL wrap read and write pointers modulo DEPTH.
REQ-024 SHALL implement the FSM states IDLE, VECTOR and SERIAL; outValid = (state != IDLE).
REQ-025 SHALL move from IDLE, on an edge where count>0, to SERIAL if serialMode=1, else to VECTOR; serialMode is sampled only at that edge and at pop edges.
REQ-026 SHALL, in VECTOR, drive outData = head entry, outLane=0 and outLast=1; outValid&outReady pops the entry.
REQ-027 SHALL, in SERIAL, drive outData lower DATA_WIDTH bits = head lane outLane with upper bits zero, and outLast=1 when outLane==VECTOR_SIZE-1.
REQ-028 SHALL, in SERIAL, increment outLane on each handshake and pop the entry and reset outLane to 0 on the handshake with outLast=1.
REQ-029 SHALL, on a pop edge, go to IDLE if the post-edge count is 0, else to SERIAL/VECTOR per serialMode at that edge, with no bubble.
REQ-030 SHALL hold outData, outLane and outLast stable while outValid=1 and outReady=0.
REQ-031 SHALL give first-beat latency: capture sampled at edge N on an empty FIFO gives outValid=1 after edge N+1.
REQ-032 SHALL ignore serialMode changes within an entry; a serial entry always emits exactly VECTOR_SIZE beats.
REQ-033 SHALL drive outputs with no combinational path from outReady or outFlag; all outputs derive from registered state.

Reset
REQ-034 SHALL, while reset=0, force state=IDLE, pointers=0, count=0, outLane=0, overflow=0, outValid=0 and outLast=0, with full=0 and outData=0.
REQ-035 SHALL, on reset assertion mid-entry, discard all stored entries and the partial serial transfer; after release, operation starts from empty.
REQ-036 SHALL NOT require the FIFO storage array to be reset; outData SHALL read 0 in IDLE.

Verification
REQ-037 SHALL verify vector mode: DEFAULT params, serialMode=0, outReady=1, one outFlag with out=0x0006_0005_0004_0003_0002_0001 -> one beat of that value, outLast=1, outValid high exactly 1 cycle, count returns to 0.
REQ-038 SHALL verify serial mode: same capture, serialMode=1, outReady=1 -> 6 beats with outData 1,2,3,4,5,6, outLane 0..5, and outLast only on the beat with outLane=5.
REQ-039 SHALL verify overflow: outReady=0, 9 consecutive outFlag pulses with values 1..9 -> count=8, full=1, overflow=1; then outReady=1 -> vectors 1..8 emitted in order and 9 is absent.
REQ-040 SHALL verify backpressure: serial mode, outReady toggling 1,0,0,1... -> no lane skipped or repeated, and payload stable during stall cycles.
REQ-041 SHALL verify mid-operation reset: reset=0 after lane 2 of a serial entry with 3 entries queued -> after release, count=0, outValid=0 and overflow=0; a new capture of 0x..07 emits from lane 0.
REQ-042 SHALL verify simultaneous push/pop: count=1 in vector mode with outReady=1 and outFlag=1 on the same edge -> count stays 1 and the new vector is the next beat with no idle cycle.
